// File: rtl/dvk_sdram_pkg.sv
// Shared types and defaults for the SDRAM initiator.
// Holds the engine state encoding, the posted-write entry layout and the
// default parameter values used by sdram_initiator and sdram_wfifo.
package dvk_sdram_pkg;

  localparam int unsigned DefaultFifoDepth = 4;
  localparam int unsigned DefaultTimeout   = 255;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StGap   = 2'd2
  } eng_state_e;

  // One posted write: word address, byte lanes, data (39 bits).
  typedef struct packed {
    logic [21:1] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
  } wentry_t;

endpackage

// File: rtl/sdram_wfifo.sv
// Posted-write FIFO for the SDRAM initiator.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  - enqueue an entry (ignored while full)
//   pop          - dequeue the head entry (ignored while empty)
//   rdata        - head entry, valid while empty=0
//   full, empty  - occupancy flags
//   count        - number of stored entries
module sdram_wfifo
  import dvk_sdram_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultFifoDepth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wentry_t                    wdata,
  input  logic                       pop,
  output wentry_t                    rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wentry_t         mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PW'(1);
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/sdram_initiator.sv
// Host-side initiator bridging the CPU Wishbone slave port to the memory bus.
// Writes are posted into a FIFO and acked immediately; reads wait until every
// posted write has completed. Each memory transaction is followed by a one-cycle
// gap, and a transaction whose strobe stays high for TIMEOUT cycles is aborted.
// Ports:
//   clk_p, sdram_reset        - clock, synchronous active-high reset
//   wb_cyc_i .. wb_dat_i      - Wishbone request
//   wb_dat_o, wb_ack_o        - Wishbone response
//   bus_err                   - one-cycle pulse on timeout abort
//   sdram_stb .. sdram_out    - memory request fields
//   sdram_ack, sdram_dat      - memory response
//   sdram_ready               - memory may accept a new request
module sdram_initiator
  import dvk_sdram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
  parameter int unsigned TIMEOUT    = DefaultTimeout
) (
  input  logic        clk_p,
  input  logic        sdram_reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [21:1] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        bus_err,
  output logic        sdram_stb,
  output logic        sdram_we,
  output logic [1:0]  sdram_sel,
  output logic [21:1] sdram_adr,
  output logic [15:0] sdram_out,
  input  logic        sdram_ack,
  input  logic [15:0] sdram_dat,
  input  logic        sdram_ready
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  eng_state_e    state_q;
  logic [TW-1:0] timer_q;
  logic          rd_q;       // transaction in flight is a read
  logic          rd_live_q;  // requesting cycle has stayed open since issue
  logic          stb_q, we_q, ack_q, err_q;
  logic [1:0]    sel_q;
  logic [21:1]   adr_q;
  logic [15:0]   out_q, dat_q;

  logic          req, push, rd_req, wr_go, rd_go, tmo, pop;
  wentry_t       push_entry, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign req        = wb_cyc_i & wb_stb_i & ~ack_q;
  assign push       = req & wb_we_i & ~fifo_full;
  assign rd_req     = req & ~wb_we_i;
  assign wr_go      = (fifo_count != '0);
  assign rd_go      = rd_req & fifo_empty;
  assign tmo        = (timer_q == TW'(TIMEOUT - 1));
  // A write leaves the FIFO only once memory has acked it or it was aborted.
  assign pop        = (state_q == StIssue) & ~rd_q & (sdram_ack | tmo);
  assign push_entry = '{adr: wb_adr_i, sel: wb_sel_i, dat: wb_dat_i};

  sdram_wfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_p),
    .rst   (sdram_reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      rd_q      <= 1'b0;
      rd_live_q <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      out_q     <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= push;
      err_q <= 1'b0;
      if (!wb_cyc_i) rd_live_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sdram_ready && (wr_go || rd_go)) begin
            state_q <= StIssue;
            stb_q   <= 1'b1;
            timer_q <= '0;
            if (wr_go) begin
              rd_q  <= 1'b0;
              we_q  <= 1'b1;
              adr_q <= head.adr;
              sel_q <= head.sel;
              out_q <= head.dat;
            end else begin
              rd_q      <= 1'b1;
              rd_live_q <= 1'b1;
              we_q      <= 1'b0;
              adr_q     <= wb_adr_i;
              sel_q     <= wb_sel_i;
              out_q     <= '0;
            end
          end
        end
        StIssue: begin
          if (sdram_ack) begin
            stb_q   <= 1'b0;
            state_q <= StGap;
            if (rd_q && rd_live_q && wb_cyc_i) begin
              ack_q <= 1'b1;
              dat_q <= sdram_dat;
            end
          end else if (tmo) begin
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StGap;
            if (rd_q && rd_live_q && wb_cyc_i) begin
              ack_q <= 1'b1;
              dat_q <= 16'hFFFF;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign bus_err   = err_q;
  assign sdram_stb = stb_q;
  assign sdram_we  = we_q;
  assign sdram_sel = sel_q;
  assign sdram_adr = adr_q;
  assign sdram_out = out_q;

endmodule

// File: tb/tb_sdram_initiator.sv
// Self-checking bench for sdram_initiator: a behavioural memory responder plus
// a reference memory image and an expected-write queue kept at the CPU side.
module tb_sdram_initiator;

  localparam int unsigned TIMEOUT = 255;

  logic        clk_p = 1'b0;
  logic        sdram_reset;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0]  wb_sel_i;
  logic [21:1] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o, bus_err;
  logic        sdram_stb, sdram_we;
  logic [1:0]  sdram_sel;
  logic [21:1] sdram_adr;
  logic [15:0] sdram_out;
  logic        sdram_ack;
  logic [15:0] sdram_dat;
  logic        sdram_ready;

  sdram_initiator #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_p       (clk_p),
    .sdram_reset (sdram_reset),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_sel_i    (wb_sel_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .bus_err     (bus_err),
    .sdram_stb   (sdram_stb),
    .sdram_we    (sdram_we),
    .sdram_sel   (sdram_sel),
    .sdram_adr   (sdram_adr),
    .sdram_out   (sdram_out),
    .sdram_ack   (sdram_ack),
    .sdram_dat   (sdram_dat),
    .sdram_ready (sdram_ready)
  );

  always #5 clk_p = ~clk_p;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ref_mem  [int];
  logic [15:0] resp_mem [int];
  logic [38:0] exp_wq [$];
  int lat_cfg     = 0;
  bit no_ack      = 1'b0;
  int stb_rises   = 0;
  int resp_acks   = 0;
  int err_pulses  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] sel);
    logic [15:0] r;
    r = old;
    if (sel[0]) r[7:0]  = d[7:0];
    if (sel[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Responder and bus monitor; samples 1 time unit after each rising edge.
  initial begin
    int wait_cnt = 0;
    int run      = 0;
    int low_run  = 100;
    int cur_lat  = 0;
    int a;
    logic prev_stb = 1'b0;
    logic [39:0] fields = '0;
    sdram_ack = 1'b0;
    sdram_dat = '0;
    forever begin
      @(posedge clk_p);
      #1;
      if (sdram_ack) begin
        check_eq("stb_after_ack", sdram_stb, 0);
        sdram_ack = 1'b0;
      end
      if (bus_err === 1'b1) err_pulses++;
      if (sdram_stb === 1'b1) begin
        if (prev_stb !== 1'b1) begin
          stb_rises++;
          check_eq("gap_min", low_run >= 2, 1);
          fields   = {sdram_we, sdram_sel, sdram_adr, sdram_out};
          cur_lat  = lat_cfg;
          run      = 0;
          wait_cnt = 0;
        end else begin
          check_eq("fields_stable", {sdram_we, sdram_sel, sdram_adr, sdram_out}, fields);
        end
        run++;
      end else begin
        if (prev_stb === 1'b1) begin
          if (!sdram_reset) check_eq("stb_cycles", run, no_ack ? TIMEOUT : cur_lat + 1);
          low_run = 0;
        end
        low_run++;
      end
      prev_stb = sdram_stb;
      if (sdram_stb === 1'b1 && !no_ack && !sdram_ack) begin
        if (wait_cnt == cur_lat) begin
          sdram_ack = 1'b1;
          resp_acks++;
          a = int'(sdram_adr);
          if (sdram_we) begin
            if (exp_wq.size() == 0) begin
              check_eq("wr_unexpected", {sdram_adr, sdram_sel, sdram_out}, 0);
            end else begin
              check_eq("wr_order", {sdram_adr, sdram_sel, sdram_out}, exp_wq.pop_front());
            end
            resp_mem[a] = merge(resp_mem.exists(a) ? resp_mem[a] : 16'h0, sdram_out, sdram_sel);
          end else begin
            sdram_dat = resp_mem.exists(a) ? resp_mem[a] : 16'h0;
          end
        end
        wait_cnt++;
      end
      if (!sdram_ack) sdram_dat = 16'($urandom);
    end
  end

  task automatic step();
    @(posedge clk_p);
    #2;
  endtask

  task automatic wb_write(input logic [21:1] adr, input logic [1:0] sel, input logic [15:0] dat,
                          output int lat);
    int a;
    if (wb_ack_o) step();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    lat = 0;
    do begin step(); lat++; end while (!wb_ack_o && lat < 3000);
    check_eq("wr_ack_seen", wb_ack_o, 1);
    if (wb_ack_o) begin
      a = int'(adr);
      ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 16'h0, dat, sel);
      exp_wq.push_back({adr, sel, dat});
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [21:1] adr, input logic [1:0] sel,
                         output logic [15:0] data, output logic err, output int lat);
    if (wb_ack_o) step();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = adr;  wb_sel_i = sel;
    lat = 0;
    do begin step(); lat++; end while (!wb_ack_o && lat < 3000);
    check_eq("rd_ack_seen", wb_ack_o, 1);
    data = wb_dat_o;
    err  = bus_err;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [21:1] adr);
    logic [15:0] d;
    logic e;
    int l, a;
    a = int'(adr);
    wb_read(adr, 2'b11, d, e, l);
    check_eq(tag, d, ref_mem.exists(a) ? ref_mem[a] : 16'h0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_wq.size() != 0 || sdram_stb) && n < 5000) begin step(); n++; end
    check_eq("drain", exp_wq.size(), 0);
    step(); step();
  endtask

  initial begin
    int l;
    int lats[6];
    int r0, e0, k;
    logic [15:0] d;
    logic e;
    bit ack_seen;

    sdram_reset = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = '0;   wb_adr_i = '0;   wb_dat_i = '0;
    sdram_ready = 1'b1;
    repeat (3) step();
    check_eq("rst_stb", sdram_stb, 0);
    check_eq("rst_ack", wb_ack_o, 0);
    check_eq("rst_err", bus_err, 0);
    check_eq("rst_dat", wb_dat_o, 0);
    check_eq("rst_fields", {sdram_we, sdram_sel, sdram_adr, sdram_out}, 0);
    sdram_reset = 1'b0;
    step();

    // Write then read back through a slow responder.
    lat_cfg = 7;
    wb_write(21'h01234, 2'b11, 16'hBEEF, l);
    check_eq("wr_lat_single", l, 1);
    wb_read(21'h01234, 2'b11, d, e, l);
    check_eq("rd_after_wr", d, 16'hBEEF);
    check_eq("rd_after_wr_err", e, 0);
    wait_drain();

    // Read latency with an idle engine and an empty FIFO.
    lat_cfg = 3;
    wb_read(21'h01234, 2'b11, d, e, l);
    check_eq("rd_idle_lat", l, 3 + 2);

    // FIFO fills behind a slow responder; the fifth write stalls.
    lat_cfg = 10;
    for (int i = 0; i < 6; i++) begin
      wb_write(21'h00200 + 21'(i), 2'b11, 16'($urandom), lats[i]);
    end
    for (int i = 0; i < 4; i++) check_eq($sformatf("wr_lat_%0d", i), lats[i], 1);
    check_eq("wr5_stalls", lats[4] > 1, 1);
    wait_drain();

    // Byte-lane write merge.
    lat_cfg = 1;
    wb_write(21'h00300, 2'b11, 16'h1234, l);
    wb_write(21'h00300, 2'b10, 16'hAA55, l);
    wb_read(21'h00300, 2'b11, d, e, l);
    check_eq("byte_merge", d, 16'hAA34);
    wait_drain();

    // Responder never acks: abort with bus_err and a 0xFFFF read.
    e0 = err_pulses;
    no_ack = 1'b1;
    wb_read(21'h00300, 2'b11, d, e, l);
    check_eq("tmo_data", d, 16'hFFFF);
    check_eq("tmo_err", e, 1);
    no_ack = 1'b0;
    step(); step();
    check_eq("tmo_err_pulses", err_pulses - e0, 1);
    lat_cfg = 2;
    wb_write(21'h00301, 2'b01, 16'h00C3, l);
    rd_expect("after_tmo", 21'h00301);
    wait_drain();

    // Reset in the middle of a transaction discards posted writes.
    lat_cfg = 20;
    for (int i = 0; i < 3; i++) wb_write(21'h00400 + 21'(i), 2'b11, 16'h5A00 + 16'(i), l);
    k = 0;
    while (!sdram_stb && k < 100) begin step(); k++; end
    check_eq("stb_before_rst", sdram_stb, 1);
    sdram_reset = 1'b1;
    step();
    check_eq("midrst_stb", sdram_stb, 0);
    check_eq("midrst_ack", wb_ack_o, 0);
    check_eq("midrst_fifo_empty", dut.fifo_empty, 1);
    sdram_reset = 1'b0;
    exp_wq.delete();
    ref_mem = resp_mem;
    r0 = stb_rises;
    repeat (40) step();
    check_eq("midrst_no_traffic", stb_rises - r0, 0);

    // Memory not ready: write is held until ready returns.
    lat_cfg = 1;
    sdram_ready = 1'b0;
    r0 = stb_rises;
    wb_write(21'h00500, 2'b11, 16'h7E57, l);
    repeat (8) step();
    check_eq("notready_no_stb", stb_rises - r0, 0);
    sdram_ready = 1'b1;
    step();
    check_eq("ready_stb", sdram_stb, 1);
    wait_drain();

    // CPU abandons a read while it is in flight: no ack is returned.
    lat_cfg = 10;
    r0 = resp_acks;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 21'h00500; wb_sel_i = 2'b11;
    k = 0;
    while (!sdram_stb && k < 100) begin step(); k++; end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ack_seen = 1'b0;
    repeat (30) begin step(); if (wb_ack_o) ack_seen = 1'b1; end
    check_eq("abandon_no_ack", ack_seen, 0);
    check_eq("abandon_mem_done", resp_acks - r0, 1);

    // Randomised traffic against the reference image.
    for (int i = 0; i < 60; i++) begin
      lat_cfg = $urandom_range(0, 4);
      if ($urandom_range(0, 2) == 0) begin
        rd_expect("rand_rd", 21'h00600 + 21'($urandom_range(0, 15)));
      end else begin
        wb_write(21'h00600 + 21'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 16'($urandom), l);
      end
    end
    wait_drain();
    for (int i = 0; i < 16; i++) rd_expect("final_rd", 21'h00600 + 21'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench time limit");
  end

endmodule
